// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution run sequencer: state encoding,
// output lane layout and small helpers.
package conv_seq_pkg;

  localparam int DATA_W  = 8;
  localparam int LANE_W  = 4 * DATA_W;
  localparam int OFF_O00 = 24;
  localparam int OFF_O01 = 16;
  localparam int OFF_O10 = 8;
  localparam int OFF_O11 = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN_PE  = 3'd2,
    ST_RUN_3B3 = 3'd3,
    ST_RUN_2B2 = 3'd4,
    ST_CHECK   = 3'd5,
    ST_SHOW    = 3'd6
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic lanes_differ(input logic [LANE_W-1:0] a,
                                        input logic [LANE_W-1:0] b);
    logic d;
    d = 1'b0;
    d = d | (a[OFF_O00 +: DATA_W] != b[OFF_O00 +: DATA_W]);
    d = d | (a[OFF_O01 +: DATA_W] != b[OFF_O01 +: DATA_W]);
    d = d | (a[OFF_O10 +: DATA_W] != b[OFF_O10 +: DATA_W]);
    d = d | (a[OFF_O11 +: DATA_W] != b[OFF_O11 +: DATA_W]);
    return d;
  endfunction

endpackage

// File: rtl/conv_sequencer_phase_timer.sv
// Loadable down-counter; `last` is registered and marks the final cycle
// of the phase that was loaded with (length - 1).
module phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             last
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      last <= 1'b0;
    end else if (load) begin
      cnt  <= value;
      last <= (value == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - WIDTH'(1);
      last <= (cnt == WIDTH'(1));
    end
  end

endmodule

// File: rtl/conv_sequencer.sv
// Run-level scheduler: sequences memory load and the three engines, captures
// each engine's result, cross-checks them and releases the display.
//
// state   | meaning
// IDLE    | all blocks held in reset, waiting for start
// LOAD    | memory running ahead of the first engine
// RUN_PE  | 1x1 PE engine running
// RUN_3B3 | 3x3 systolic engine running
// RUN_2B2 | 2x2 systolic engine running
// CHECK   | one cycle to compare the captured results
// SHOW    | display released
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int LOAD_CYCLES = 4,
  parameter int PE_CYCLES   = 20,
  parameter int T3_CYCLES   = 8,
  parameter int T2_CYCLES   = 10,
  parameter int DISP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] o_pe,
  input  logic [31:0] o_3b3,
  input  logic [31:0] o_2b2,
  output logic        rst_mem,
  output logic        rst_pe,
  output logic        rst_3b3,
  output logic        rst_2b2,
  output logic        rst_disp,
  output logic [31:0] res_pe,
  output logic [31:0] res_3b3,
  output logic [31:0] res_2b2,
  output logic        mismatch,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  localparam int MAX_CYC = max2(max2(max2(LOAD_CYCLES, PE_CYCLES),
                                     max2(T3_CYCLES, T2_CYCLES)), DISP_CYCLES);
  localparam int TW = $clog2(MAX_CYC) + 1;

  state_t          cur_st, nxt_st;
  logic            t_load, t_last;
  logic [TW-1:0]   load_val;
  logic            entering_load;

  assign state         = cur_st;
  assign busy          = !((cur_st == ST_IDLE) || (cur_st == ST_SHOW));
  assign t_load        = (nxt_st != cur_st);
  assign entering_load = (nxt_st == ST_LOAD) && (cur_st != ST_LOAD);

  phase_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (t_load),
    .value (load_val),
    .last  (t_last)
  );

  always_comb begin
    nxt_st = cur_st;
    if (abort) begin
      nxt_st = ST_IDLE;
    end else begin
      case (cur_st)
        ST_IDLE:    if (start)  nxt_st = ST_LOAD;
        ST_LOAD:    if (t_last) nxt_st = ST_RUN_PE;
        ST_RUN_PE:  if (t_last) nxt_st = ST_RUN_3B3;
        ST_RUN_3B3: if (t_last) nxt_st = ST_RUN_2B2;
        ST_RUN_2B2: if (t_last) nxt_st = ST_CHECK;
        ST_CHECK:   nxt_st = ST_SHOW;
        ST_SHOW: begin
          if (start)                          nxt_st = ST_LOAD;
          else if (DISP_CYCLES > 0 && t_last) nxt_st = ST_IDLE;
        end
        default:    nxt_st = ST_IDLE;
      endcase
    end
  end

  // Timer is loaded with (length - 1) for whichever state is being entered.
  always_comb begin
    load_val = '0;
    case (nxt_st)
      ST_LOAD:    load_val = TW'(LOAD_CYCLES - 1);
      ST_RUN_PE:  load_val = TW'(PE_CYCLES - 1);
      ST_RUN_3B3: load_val = TW'(T3_CYCLES - 1);
      ST_RUN_2B2: load_val = TW'(T2_CYCLES - 1);
      ST_SHOW:    load_val = (DISP_CYCLES > 0) ? TW'(DISP_CYCLES - 1) : '0;
      default:    load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st   <= ST_IDLE;
      rst_mem  <= 1'b0;
      rst_pe   <= 1'b0;
      rst_3b3  <= 1'b0;
      rst_2b2  <= 1'b0;
      rst_disp <= 1'b0;
      done     <= 1'b0;
      res_pe   <= '0;
      res_3b3  <= '0;
      res_2b2  <= '0;
      mismatch <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      rst_mem  <= (nxt_st != ST_IDLE);
      rst_pe   <= (nxt_st == ST_RUN_PE);
      rst_3b3  <= (nxt_st == ST_RUN_3B3);
      rst_2b2  <= (nxt_st == ST_RUN_2B2);
      rst_disp <= (nxt_st == ST_SHOW);
      done     <= (nxt_st == ST_SHOW) && (cur_st != ST_SHOW);
      if (entering_load) begin
        res_pe   <= '0;
        res_3b3  <= '0;
        res_2b2  <= '0;
        mismatch <= 1'b0;
      end else if (!abort) begin
        // An aborted run keeps whatever was captured before the abort.
        case (cur_st)
          ST_RUN_PE:  if (t_last) res_pe  <= o_pe;
          ST_RUN_3B3: if (t_last) res_3b3 <= o_3b3;
          ST_RUN_2B2: if (t_last) res_2b2 <= o_2b2;
          ST_CHECK:   mismatch <= lanes_differ(res_pe, res_3b3) |
                                  lanes_differ(res_3b3, res_2b2);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: default instance, a hold-SHOW instance
// (DISP_CYCLES=0) and an all-ones-length instance share the same stimulus.
module tb_conv_sequencer;

  localparam logic [31:0] NOM = 32'h0A141E28;
  localparam logic [31:0] BAD = 32'h0A141E29;
  localparam logic [31:0] ALT = 32'h11223344;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] o_pe = '0, o_3b3 = '0, o_2b2 = '0;

  logic        rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp, mismatch, busy, done;
  logic [31:0] res_pe, res_3b3, res_2b2;
  logic [2:0]  state;

  logic        rst_mem0, rst_pe0, rst_3b30, rst_2b20, rst_disp0, mismatch0, busy0, done0;
  logic [31:0] res_pe0, res_3b30, res_2b20;
  logic [2:0]  state0;

  logic        rst_mem1, rst_pe1, rst_3b31, rst_2b21, rst_disp1, mismatch1, busy1, done1;
  logic [31:0] res_pe1, res_3b31, res_2b21;
  logic [2:0]  state1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  conv_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .o_pe(o_pe), .o_3b3(o_3b3), .o_2b2(o_2b2),
    .rst_mem(rst_mem), .rst_pe(rst_pe), .rst_3b3(rst_3b3), .rst_2b2(rst_2b2),
    .rst_disp(rst_disp), .res_pe(res_pe), .res_3b3(res_3b3), .res_2b2(res_2b2),
    .mismatch(mismatch), .busy(busy), .done(done), .state(state)
  );

  conv_sequencer #(.DISP_CYCLES(0)) u_hold (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .o_pe(o_pe), .o_3b3(o_3b3), .o_2b2(o_2b2),
    .rst_mem(rst_mem0), .rst_pe(rst_pe0), .rst_3b3(rst_3b30), .rst_2b2(rst_2b20),
    .rst_disp(rst_disp0), .res_pe(res_pe0), .res_3b3(res_3b30), .res_2b2(res_2b20),
    .mismatch(mismatch0), .busy(busy0), .done(done0), .state(state0)
  );

  conv_sequencer #(.LOAD_CYCLES(1), .PE_CYCLES(1), .T3_CYCLES(1), .T2_CYCLES(1),
                   .DISP_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .o_pe(o_pe), .o_3b3(o_3b3), .o_2b2(o_2b2),
    .rst_mem(rst_mem1), .rst_pe(rst_pe1), .rst_3b3(rst_3b31), .rst_2b2(rst_2b21),
    .rst_disp(rst_disp1), .res_pe(res_pe1), .res_3b3(res_3b31), .res_2b2(res_2b21),
    .mismatch(mismatch1), .busy(busy1), .done(done1), .state(state1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    tests++; if ({rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp} !== 5'b0) begin
      fails++; $display("FAIL reset_lines: got %b want 00000", {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp}); end
    tests++; if ({res_pe, res_3b3, res_2b2} !== 96'h0) begin
      fails++; $display("FAIL reset_results: got %h want 0", {res_pe, res_3b3, res_2b2}); end
    tests++; if ({mismatch, busy, done} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {mismatch, busy, done}); end
    step();
    rst = 1'b1;
    step();
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL idle_after_reset: got %0d want 0", state); end
  endtask

  task automatic test_nominal();
    int n, pe_c, t3_c, t2_c, ovl, fast_at, d, dc;
    o_pe = NOM; o_3b3 = NOM; o_2b2 = NOM;
    pulse_start();
    tests++; if ({state, rst_mem, busy} !== {3'd1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL nom_load_entry: got state %0d rst_mem %b busy %b want 1 1 1", state, rst_mem, busy); end
    n = 0; pe_c = 0; t3_c = 0; t2_c = 0; ovl = 0; fast_at = -1;
    while (!done && n < 200) begin
      pe_c += int'(rst_pe); t3_c += int'(rst_3b3); t2_c += int'(rst_2b2);
      if (int'(rst_pe) + int'(rst_3b3) + int'(rst_2b2) > 1) ovl++;
      if (done1 && fast_at < 0) fast_at = n;
      step();
      n++;
    end
    tests++; if (n != 43) begin fails++; $display("FAIL nom_done_latency: got %0d want 43", n); end
    tests++; if (pe_c != 20) begin fails++; $display("FAIL win_rst_pe: got %0d want 20", pe_c); end
    tests++; if (t3_c != 8) begin fails++; $display("FAIL win_rst_3b3: got %0d want 8", t3_c); end
    tests++; if (t2_c != 10) begin fails++; $display("FAIL win_rst_2b2: got %0d want 10", t2_c); end
    tests++; if (ovl != 0) begin fails++; $display("FAIL win_overlap: got %0d want 0", ovl); end
    tests++; if (fast_at != 5) begin fails++; $display("FAIL fast_done_latency: got %0d want 5", fast_at); end
    tests++; if ({res_pe1, res_3b31, res_2b21} !== {NOM, NOM, NOM}) begin
      fails++; $display("FAIL fast_capture: got %h want %h", {res_pe1, res_3b31, res_2b21}, {NOM, NOM, NOM}); end
    tests++; if ({res_pe, res_3b3, res_2b2} !== {NOM, NOM, NOM}) begin
      fails++; $display("FAIL nom_results: got %h want %h", {res_pe, res_3b3, res_2b2}, {NOM, NOM, NOM}); end
    tests++; if ({state, mismatch, busy, rst_disp, rst_mem} !== {3'd6, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL nom_show: got state %0d mm %b busy %b disp %b mem %b want 6 0 0 1 1",
                        state, mismatch, busy, rst_disp, rst_mem); end
    d = 0; dc = 0;
    while (rst_disp && d < 100) begin
      d++;
      dc += int'(done);
      step();
    end
    tests++; if (d != 16) begin fails++; $display("FAIL nom_disp_cycles: got %0d want 16", d); end
    tests++; if (dc != 1) begin fails++; $display("FAIL nom_done_width: got %0d want 1", dc); end
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL nom_back_idle: got %0d want 0", state); end
  endtask

  task automatic test_disp_hold();
    repeat (20) step();
    tests++; if ({state0, rst_disp0, busy0} !== {3'd6, 1'b1, 1'b0}) begin
      fails++; $display("FAIL hold_show: got state %0d disp %b busy %b want 6 1 0", state0, rst_disp0, busy0); end
    tests++; if (res_pe0 !== NOM) begin fails++; $display("FAIL hold_result: got %h want %h", res_pe0, NOM); end
    pulse_start();
    tests++; if ({state0, rst_disp0} !== {3'd1, 1'b0}) begin
      fails++; $display("FAIL hold_restart: got state %0d disp %b want 1 0", state0, rst_disp0); end
    tests++; if ({res_pe0, mismatch0} !== 33'h0) begin
      fails++; $display("FAIL hold_clear: got %h %b want 0 0", res_pe0, mismatch0); end
    go_idle();
    tests++; if ({state0, state, rst_mem0} !== 7'b0) begin
      fails++; $display("FAIL hold_abort: got %0d %0d %b want 0 0 0", state0, state, rst_mem0); end
  endtask

  task automatic test_mismatch();
    o_pe = NOM; o_3b3 = NOM; o_2b2 = BAD;
    pulse_start();
    repeat (42) step();
    tests++; if ({state, mismatch} !== {3'd5, 1'b0}) begin
      fails++; $display("FAIL mm_check_state: got state %0d mm %b want 5 0", state, mismatch); end
    step();
    tests++; if ({state, mismatch, done} !== {3'd6, 1'b1, 1'b1}) begin
      fails++; $display("FAIL mm_show: got state %0d mm %b done %b want 6 1 1", state, mismatch, done); end
    tests++; if ({res_pe, res_2b2} !== {NOM, BAD}) begin
      fails++; $display("FAIL mm_results: got %h want %h", {res_pe, res_2b2}, {NOM, BAD}); end
    go_idle();
    tests++; if ({state, mismatch} !== {3'd0, 1'b1}) begin
      fails++; $display("FAIL mm_held: got state %0d mm %b want 0 1", state, mismatch); end
    o_2b2 = NOM;
  endtask

  task automatic test_ignored_start();
    int n;
    pulse_start();
    repeat (5) step();
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL ign_in_pe: got %0d want 2", state); end
    pulse_start();
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL ign_still_pe: got %0d want 2", state); end
    n = 6;
    while (!done && n < 200) begin
      step();
      n++;
    end
    tests++; if (n != 43) begin fails++; $display("FAIL ign_latency: got %0d want 43", n); end
    go_idle();
  endtask

  task automatic test_abort();
    int dc;
    o_pe = ALT;
    pulse_start();
    repeat (26) step();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL abort_pre_state: got %0d want 3", state); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests++; if ({state, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL abort_idle: got state %0d busy %b done %b want 0 0 0", state, busy, done); end
    tests++; if ({rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp} !== 5'b0) begin
      fails++; $display("FAIL abort_lines: got %b want 00000", {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp}); end
    tests++; if ({res_pe, res_3b3, res_2b2, mismatch} !== {ALT, 32'h0, 32'h0, 1'b0}) begin
      fails++; $display("FAIL abort_results: got %h %h %h %b want %h 0 0 0",
                        res_pe, res_3b3, res_2b2, mismatch, ALT); end
    dc = 0;
    repeat (50) begin
      dc += int'(done);
      step();
    end
    tests++; if ({dc != 0, state} !== 4'd0) begin
      fails++; $display("FAIL abort_no_done: got %0d pulses state %0d want 0 0", dc, state); end
    o_pe = NOM;
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    tests++; if ({state, rst_mem, busy} !== 5'b0) begin
      fails++; $display("FAIL prio_idle: got state %0d mem %b busy %b want 0 0 0", state, rst_mem, busy); end
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (42) step();
    tests++; if ({state, res_pe} !== {3'd5, NOM}) begin
      fails++; $display("FAIL areset_pre: got state %0d res %h want 5 %h", state, res_pe, NOM); end
    #2 rst = 1'b0;
    #1;
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL areset_state: got %0d want 0", state); end
    tests++; if ({rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp} !== 5'b0) begin
      fails++; $display("FAIL areset_lines: got %b want 00000", {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp}); end
    tests++; if ({res_pe, res_3b3, res_2b2, mismatch, busy, done} !== 99'h0) begin
      fails++; $display("FAIL areset_data: got %h %h %h %b%b%b want 0",
                        res_pe, res_3b3, res_2b2, mismatch, busy, done); end
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_disp_hold();
    test_mismatch();
    test_ignored_start();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
